uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame; legal range 5..8.
REQ-003 SHALL use clock i_clk and reset i_rst_n, asynchronous, active-low.
REQ-004 i_clk  input  1  system clock; all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_rx_serial  input  1  asynchronous serial line, idle high, LSB first, 1 start, DATA_WIDTH data, 1 stop, no parity.
REQ-007 o_rx_dv  output  1  one-cycle pulse: o_rx_byte holds a newly received, correctly framed byte.
REQ-008 o_rx_byte  output  DATA_WIDTH  last good received byte; held until next good frame.
REQ-009 o_rx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 i_rx_serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP; unused encodings -> IDLE.
REQ-013 Bit counter SHALL be 16 bits, counts 0..CLKS_PER_BIT-1, cleared on every state change; H = (CLKS_PER_BIT-1)/2 (integer).
REQ-014 IDLE: SHALL go to START_BIT only on a synchronized high-to-low transition (previous cycle high, current low); a line held low never re-triggers.
REQ-015 START_BIT: at count H, decision value low -> DATA_BITS; high -> IDLE (glitch rejected, no o_rx_dv, no o_frame_err).
REQ-016 DATA_BITS: at count CLKS_PER_BIT-1, decision value SHALL be stored at bit index (0 first); after index DATA_WIDTH-1 -> STOP_BIT, index cleared.
REQ-017 STOP_BIT: at count CLKS_PER_BIT-1, decision value high -> o_rx_byte loaded from shift data and o_rx_dv pulsed; low -> o_frame_err pulsed, o_rx_byte unchanged; either case -> CLEANUP.
REQ-018 CLEANUP: one cycle, SHALL clear o_rx_dv/o_frame_err, -> IDLE.
REQ-019 o_rx_dv and o_frame_err SHALL never assert in the same cycle and each SHALL be high exactly one cycle per frame.
REQ-020 Latency: if edge k0 is the first rising edge sampling i_rx_serial low, o_rx_dv/o_frame_err SHALL be registered high at edge k0+3+H+(DATA_WIDTH+1)*CLKS_PER_BIT (4125 at defaults).
REQ-021 Back-to-back frames with no idle gap SHALL be received without loss (FSM reaches IDLE before next start edge).

Reset
REQ-022 On i_rst_n low, immediately: state IDLE, counter 0, bit index 0, shift data 0, o_rx_byte 0, o_rx_dv 0, o_rx_busy 0, o_frame_err 0, synchronizer flops and edge-history flop 1.
REQ-023 Reset mid-frame SHALL abort the frame with no o_rx_dv/o_frame_err; reception resumes only on the next high-to-low transition after release.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN defined: every decision value (REQ-015..017) SHALL be the 2-of-3 majority of the synchronized line in the decision cycle and the two preceding cycles; timing unchanged.
REQ-025 Macro UART_RX_MAJORITY_EN undefined: decision value SHALL be the synchronized line in the decision cycle only; no history registers.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8, H=7 unless stated)
REQ-026 Send 0xA5 from uart_tx (same parameters) -> one o_rx_dv pulse at edge k0+154, o_rx_byte=0xA5, o_frame_err never high.
REQ-027 Send 0x00, 0xFF, 0x3C back-to-back, no gap -> three o_rx_dv pulses, bytes 0x00, 0xFF, 0x3C in order.
REQ-028 Drive line low 4 cycles then high -> o_rx_busy high briefly, returns IDLE, no o_rx_dv, no o_frame_err.
REQ-029 Send 0x55 with stop bit forced low, then hold low 400 cycles -> one o_frame_err pulse, o_rx_byte keeps prior value, no further starts until line returns high.
REQ-030 Assert i_rst_n low during bit 3 of 0x81, release, send 0x42 -> all outputs 0 during reset, then only 0x42 received.
REQ-031 With UART_RX_MAJORITY_EN, 1-cycle inverted glitch at every decision point of 0x96 -> o_rx_byte=0x96; without macro, byte corrupted.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, 8N1-style framing, LSB first.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_serial,
    output logic                  o_rx_dv,
    output logic [DATA_WIDTH-1:0] o_rx_byte,
    output logic                  o_rx_busy,
    output logic                  o_frame_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF    = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]  TOP_IDX = 3'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_n;
    logic [15:0]           cnt;
    logic [2:0]            idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  sync_a;
    logic                  sync_b;
    logic                  prev;
    logic                  decision;
    logic                  cnt_clr;
    logic                  store_bit;
    logic                  good_stop;
    logic                  bad_stop;

    // Bring the asynchronous line into the clock domain and keep edge history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= i_rx_serial;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic hist_a;
    logic hist_b;

    // Two cycles of synchronized history feed the majority vote.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_a <= 1'b1;
            hist_b <= 1'b1;
        end else begin
            hist_a <= sync_b;
            hist_b <= hist_a;
        end
    end

    assign decision = (sync_b & hist_a) | (sync_b & hist_b) | (hist_a & hist_b);
`else
    assign decision = sync_b;
`endif

    assign o_rx_busy = (state != IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        store_bit = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (prev && !sync_b) begin
                    state_n = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt == HALF) begin
                    state_n = decision ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (cnt == LAST) begin
                    store_bit = 1'b1;
                    cnt_clr   = 1'b1;
                    if (idx == TOP_IDX) begin
                        state_n = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                if (cnt == LAST) begin
                    good_stop = decision;
                    bad_stop  = !decision;
                    state_n   = CLEANUP;
                end
            end
            CLEANUP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n != state) begin
            cnt_clr = 1'b1;
        end
    end

    // Bit timing counter, shift register and registered result pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_rx_byte   <= '0;
            o_rx_dv     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 16'd1;
            if (store_bit) begin
                shift[idx] <= decision;
                idx        <= (idx == TOP_IDX) ? 3'd0 : idx + 3'd1;
            end
            if (good_stop) begin
                o_rx_byte <= shift;
            end
            o_rx_dv     <= good_stop;
            o_frame_err <= bad_stop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16, DATA_WIDTH=8.
// Frames are modelled as whole events: byte or framing error at k0+154.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;
    localparam int LAT = 3 + (CPB - 1) / 2 + (DW + 1) * CPB;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_rx_serial;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;
    logic       o_rx_busy;
    logic       o_frame_err;

    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] last_good;
    exp_t       sb[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (DW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_serial(i_rx_serial),
        .o_rx_dv    (o_rx_dv),
        .o_rx_byte  (o_rx_byte),
        .o_rx_busy  (o_rx_busy),
        .o_frame_err(o_frame_err)
    );

    // Free-running clock and edge counter.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n && (o_rx_dv || o_frame_err)) begin
            chk("dv_err_exclusive", int'(o_rx_dv && o_frame_err), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: dv=%0b err=%0b byte=%0h expected none",
                         o_rx_dv, o_frame_err, o_rx_byte);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", int'(o_frame_err), int'(e.err));
                chk("rx_byte", int'(o_rx_byte), int'(e.data));
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Hold one serial bit for CPB cycles, optionally inverting the mid-bit sample.
    task automatic drive_bit(input logic b, input bit glitch);
        for (int t = 0; t < CPB; t++) begin
            i_rx_serial = (glitch && t == CPB / 2) ? ~b : b;
            @(negedge i_clk);
        end
    endtask

    task automatic idle(input int n);
        i_rx_serial = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    // Send one frame; the model predicts the whole-frame outcome.
    task automatic send(input logic [7:0] d, input bit stop, input bit glitch);
        exp_t       e;
        logic [7:0] seen;
        bit         g_edge;
`ifdef UART_RX_MAJORITY_EN
        seen   = d;
        g_edge = glitch;
`else
        seen   = glitch ? ~d : d;
        g_edge = 1'b0;
`endif
        e.cyc = cyc + 1 + LAT;
        if (stop) begin
            e.err     = 1'b0;
            e.data    = seen;
            last_good = seen;
        end else begin
            e.err  = 1'b1;
            e.data = last_good;
        end
        sb.push_back(e);
        drive_bit(1'b0, g_edge);
        for (int j = 0; j < DW; j++) begin
            drive_bit(d[j], glitch);
        end
        drive_bit(stop, g_edge);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dv"}, int'(o_rx_dv), 0);
        chk({tag, "_byte"}, int'(o_rx_byte), 0);
        chk({tag, "_busy"}, int'(o_rx_busy), 0);
        chk({tag, "_ferr"}, int'(o_frame_err), 0);
    endtask

    initial begin
        int busy_cnt;
        int wait_cnt;
        logic [7:0] d;
        checks      = 0;
        errors      = 0;
        last_good   = 8'h00;
        i_rx_serial = 1'b1;
        i_rst_n     = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;
        idle(5);

        // Single clean frame with exact latency.
        send(8'hA5, 1'b1, 1'b0);
        idle(10);

        // Back-to-back frames, no idle gap.
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        idle(10);

        // Short low pulse must be rejected as a glitch.
        busy_cnt = 0;
        i_rx_serial = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rx_serial = 1'b1;
        repeat (30) begin
            @(negedge i_clk);
            if (o_rx_busy) busy_cnt++;
        end
        chk("glitch_busy_seen", int'(busy_cnt > 0), 1);
        chk("glitch_busy_end", int'(o_rx_busy), 0);

        // Framing error, then line stuck low must not re-trigger.
        send(8'h55, 1'b0, 1'b0);
        i_rx_serial = 1'b0;
        repeat (400) @(negedge i_clk);
        chk("stuck_low_idle", int'(o_rx_busy), 0);
        idle(10);
        send(8'h5A, 1'b1, 1'b0);
        idle(5);

        // Reset during bit 3 of 0x81 aborts the frame.
        d = 8'h81;
        drive_bit(1'b0, 1'b0);
        for (int j = 0; j < 3; j++) drive_bit(d[j], 1'b0);
        i_rx_serial = d[3];
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        last_good = 8'h00;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("midreset");
        i_rx_serial = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(5);
        send(8'h42, 1'b1, 1'b0);
        idle(5);

        // Single-cycle glitches at the decision points.
        send(8'h96, 1'b1, 1'b1);
        idle(5);

        // Randomized traffic: data, stop errors and gaps.
        for (int n = 0; n < 24; n++) begin
            bit stop;
            int gap;
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 12);
            send(8'($urandom()), stop, 1'b0);
            if (!stop && gap < 3) gap = 3;
            if (gap > 0) idle(gap);
        end

        idle(20);
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 2000) begin
            @(negedge i_clk);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pulses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
